// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers completed MEM-stage results in a 2-entry in-order queue,
// finalises load data at push time and drives the register file write port one entry per cycle.
module wb_commit_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              wb_hold,
  input  logic              flush,
  output logic              isWB,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired_count
);

  logic              ent_reg_write_q [2];
  logic [REG_AW-1:0] ent_rd_q        [2];
  logic [DATA_W-1:0] ent_data_q      [2];

  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] retired_q, retired_d;

  logic              push, pop, head_valid, head_writes;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] push_data;

  // Load alignment and extension happen before the entry is stored.
  always_comb begin
    ld_byte = in_mem_data[7:0];
    unique case (in_alu_result[1:0])
      2'd0: ld_byte = in_mem_data[7:0];
      2'd1: ld_byte = in_mem_data[15:8];
      2'd2: ld_byte = in_mem_data[23:16];
      2'd3: ld_byte = in_mem_data[31:24];
      default: ld_byte = in_mem_data[7:0];
    endcase
    ld_half = in_alu_result[1] ? in_mem_data[31:16] : in_mem_data[15:0];

    unique case (in_load_size)
      2'b01:   push_data = {{(DATA_W-16){~in_load_unsigned & ld_half[15]}}, ld_half};
      2'b10:   push_data = {{(DATA_W-8){~in_load_unsigned & ld_byte[7]}}, ld_byte};
      default: push_data = in_mem_data;
    endcase
    if (!in_mem_to_reg) begin
      push_data = in_alu_result;
    end
  end

  assign in_ready    = (count_q < 2'd2);
  assign head_valid  = (count_q != 2'd0);
  assign push        = in_valid & in_ready;
  assign pop         = head_valid & ~wb_hold;
  assign head_writes = head_valid & ent_reg_write_q[head_q] & (ent_rd_q[head_q] != '0);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    retired_d = retired_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        tail_d = ~tail_q;
      end
      if (pop) begin
        head_d    = ~head_q;
        retired_d = retired_q + 32'd1;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (pop && !push) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      retired_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        ent_reg_write_q[i] <= 1'b0;
        ent_rd_q[i]        <= '0;
        ent_data_q[i]      <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      retired_q <= retired_d;
      if (push && !flush) begin
        ent_reg_write_q[tail_q] <= in_reg_write;
        ent_rd_q[tail_q]        <= in_rd;
        ent_data_q[tail_q]      <= push_data;
      end
    end
  end

  // The write port is not gated by flush: the head write in the flush cycle still lands.
  always_comb begin
    isWB       = head_writes & ~wb_hold;
    write_reg  = head_valid ? ent_rd_q[head_q] : '0;
    write_data = head_valid ? ent_data_q[head_q] : '0;
    fwd_valid  = head_writes;
    fwd_reg    = write_reg;
    fwd_data   = write_data;
  end

  assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: a reference queue model is pushed on stimulus and
// popped when the DUT should retire, with a load-extension vector table and corner sequences.
module tb_wb_commit_queue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_mem_data;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned, wb_hold, flush;
  logic        isWB, fwd_valid;
  logic [4:0]  write_reg, fwd_reg;
  logic [31:0] write_data, fwd_data, retired_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_retired = 32'd0;

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] mem;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  wb_commit_queue #(.DATA_W(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_reg_write     (in_reg_write),
    .in_mem_to_reg    (in_mem_to_reg),
    .in_rd            (in_rd),
    .in_alu_result    (in_alu_result),
    .in_mem_data      (in_mem_data),
    .in_load_size     (in_load_size),
    .in_load_unsigned (in_load_unsigned),
    .wb_hold          (wb_hold),
    .flush            (flush),
    .isWB             (isWB),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .fwd_valid        (fwd_valid),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data),
    .retired_count    (retired_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] sz,
                       input logic uns, input logic hold, input logic fl, input logic r,
                       input logic [31:0] exp_data);
    ent_t        h;
    logic        m_valid, m_wr, m_push, m_pop;
    @(negedge clk);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd;
    in_alu_result = alu; in_mem_data = mem; in_load_size = sz; in_load_unsigned = uns;
    wb_hold = hold; flush = fl; rst = r;
    #1;
    m_valid = (mq.size() != 0);
    h = m_valid ? mq[0] : '{rw: 1'b0, rd: 5'd0, data: 32'd0};
    m_wr = m_valid && h.rw && (h.rd != 5'd0);
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("isWB", {31'd0, isWB}, {31'd0, m_wr && !hold});
    chk("write_reg", {27'd0, write_reg}, {27'd0, h.rd});
    chk("write_data", write_data, h.data);
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_wr});
    chk("fwd_reg", {27'd0, fwd_reg}, {27'd0, h.rd});
    chk("fwd_data", fwd_data, h.data);
    chk("retired_count", retired_count, m_retired);
    m_push = v && (mq.size() < 2);
    m_pop = m_valid && !hold;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_retired = 32'd0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        m_retired++;
      end
      if (m_push) mq.push_back('{rw: rw, rd: rd, data: exp_data});
    end
  endtask

  task automatic idle(input logic hold);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, hold, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push_alu(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                          input logic hold);
    cycle(1'b1, rw, 1'b0, rd, alu, 32'hDEAD_BEEF, 2'b00, 1'b0, hold, 1'b0, 1'b0, alu);
  endtask

  initial begin
    vecs[0] = '{size: 2'b10, uns: 1'b0, off: 2'd1, mem: 32'h80FF7F01, exp: 32'h0000007F};
    vecs[1] = '{size: 2'b10, uns: 1'b0, off: 2'd3, mem: 32'h80FF7F01, exp: 32'hFFFFFF80};
    vecs[2] = '{size: 2'b01, uns: 1'b1, off: 2'd2, mem: 32'h80FF7F01, exp: 32'h000080FF};
    vecs[3] = '{size: 2'b01, uns: 1'b0, off: 2'd0, mem: 32'h80FF7F01, exp: 32'h00007F01};
    vecs[4] = '{size: 2'b00, uns: 1'b0, off: 2'd2, mem: 32'h80FF7F01, exp: 32'h80FF7F01};
    vecs[5] = '{size: 2'b10, uns: 1'b1, off: 2'd0, mem: 32'h80FF7F01, exp: 32'h00000001};
    vecs[6] = '{size: 2'b10, uns: 1'b0, off: 2'd2, mem: 32'h80FF7F01, exp: 32'hFFFFFFFF};
    vecs[7] = '{size: 2'b01, uns: 1'b0, off: 2'd3, mem: 32'h80FF7F01, exp: 32'hFFFF80FF};
    vecs[8] = '{size: 2'b11, uns: 1'b1, off: 2'd1, mem: 32'h80FF7F01, exp: 32'h80FF7F01};

    rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_rd = 5'd0;
    in_alu_result = 32'd0; in_mem_data = 32'd0; in_load_size = 2'b00;
    in_load_unsigned = 1'b0; wb_hold = 1'b0; flush = 1'b0;

    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    idle(1'b0);

    // ALU writeback
    push_alu(1'b1, 5'd3, 32'h0000002A, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Load extension table
    foreach (vecs[i]) begin
      cycle(1'b1, 1'b1, 1'b1, 5'd7, {30'h0000_0100, vecs[i].off}, vecs[i].mem, vecs[i].size,
            vecs[i].uns, 1'b0, 1'b0, 1'b0, vecs[i].exp);
      idle(1'b0);
    end
    idle(1'b0);

    // Backpressure
    push_alu(1'b1, 5'd1, 32'h1111_0001, 1'b1);
    push_alu(1'b1, 5'd2, 32'h2222_0002, 1'b1);
    push_alu(1'b1, 5'd9, 32'h9999_0009, 1'b1);  // refused: queue full
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // r0 and no-write entries
    push_alu(1'b1, 5'd0, 32'h0000_00AA, 1'b0);
    push_alu(1'b0, 5'd5, 32'h0000_00BB, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Flush under hold
    push_alu(1'b1, 5'd4, 32'h4444_0004, 1'b1);
    push_alu(1'b1, 5'd6, 32'h6666_0006, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(1'b1);
    idle(1'b0);

    // Refill then reset mid-operation
    push_alu(1'b1, 5'd8, 32'h8888_0008, 1'b1);
    push_alu(1'b1, 5'd10, 32'hAAAA_000A, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    idle(1'b0);
    idle(1'b0);

    // Streaming: 8 back-to-back pushes
    for (int i = 0; i < 8; i++) begin
      push_alu(1'b1, 5'(i + 11), 32'hC0DE_0000 + 32'(i), 1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    chk("stream_retired", retired_count, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
